// File: rtl/online_to_conv_pkg.sv
// rtl/online_to_conv_pkg.sv - shared online-arithmetic digit codes and FSM states
package online_to_conv_pkg;

  // Signed-digit codes; 2'b00 and 2'b11 both mean zero.
  localparam logic [1:0] POS = 2'b10;
  localparam logic [1:0] NEG = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CONV = 2'b01,
    DONE = 2'b10
  } conv_state_t;

endpackage

// File: rtl/otf_digit_update.sv
// rtl/otf_digit_update.sv - one on-the-fly conversion step for the Q/QM register pair
module otf_digit_update
  import online_to_conv_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N:0] q,
  input  logic [N:0] qm,
  input  logic [1:0] digit,
  output logic [N:0] q_next,
  output logic [N:0] qm_next
);

  // QM always tracks Q minus one ulp, so a -1 digit never needs a borrow chain.
  always_comb begin
    q_next  = {q[N-1:0], 1'b0};
    qm_next = {qm[N-1:0], 1'b1};
    case (digit)
      POS: begin
        q_next  = {q[N-1:0], 1'b1};
        qm_next = {q[N-1:0], 1'b0};
      end
      NEG: begin
        q_next  = {qm[N-1:0], 1'b1};
        qm_next = {qm[N-1:0], 1'b0};
      end
      default: begin
        q_next  = {q[N-1:0], 1'b0};
        qm_next = {qm[N-1:0], 1'b1};
      end
    endcase
  end

endmodule

// File: rtl/online_to_conv.sv
// rtl/online_to_conv.sv - serial signed-digit to two's-complement converter, one digit per cycle
module online_to_conv
  import online_to_conv_pkg::*;
#(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2*N-1:0] in_z,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N:0]    out_q
);

  localparam int WL = 2 * N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  conv_state_t   state, state_next;
  logic [CW-1:0] cnt;
  logic [WL-1:0] sreg;
  logic [N:0]    q, qm;
  logic [N:0]    q_upd, qm_upd;
  logic          accept;
  logic          last_digit;

  otf_digit_update #(.N(N)) u_update (
    .q       (q),
    .qm      (qm),
    .digit   (sreg[WL-1 -: 2]),
    .q_next  (q_upd),
    .qm_next (qm_upd)
  );

  assign last_digit = (cnt == CW'(N - 1));
  assign accept     = in_valid && in_ready;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CONV;
      end
      CONV: begin
        if (last_digit) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        // Handing off the result and taking the next word share one cycle.
        if (out_ready) state_next = in_valid ? CONV : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
      q     <= '0;
      qm    <= '1;
    end else begin
      state <= state_next;
      if (accept) begin
        sreg <= in_z;
        q    <= '0;
        qm   <= '1;
        cnt  <= '0;
      end else if (state == CONV) begin
        sreg <= {sreg[WL-3:0], 2'b00};
        q    <= q_upd;
        qm   <= qm_upd;
        cnt  <= cnt + CW'(1);
      end
    end
  end

  assign out_q = q;

endmodule

// File: tb/tb_online_to_conv.sv
// tb/tb_online_to_conv.sv - self-checking bench for online_to_conv
module tb_online_to_conv;

  localparam int N  = 8;
  localparam int WL = 2 * N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WL-1:0] in_z = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [N:0]    out_q;

  int checks = 0;
  int failures = 0;

  online_to_conv #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_z      (in_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q)
  );

  always #5 clk = ~clk;

  // Value of the word times 2^N: sum of digit_k * 2^(N-1-k).
  function automatic logic [N:0] ref_val(input logic [WL-1:0] z);
    int v;
    logic [1:0] d;
    v = 0;
    for (int k = 0; k < N; k++) begin
      d = z[WL-1-2*k -: 2];
      if (d == 2'b10) v = v + (1 << (N - 1 - k));
      else if (d == 2'b01) v = v - (1 << (N - 1 - k));
    end
    return v[N:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge after the accepting edge; waits for out_valid and checks latency/value.
  task automatic wait_result(input string tag, input logic [N:0] exp);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, N);
    chk({tag, "_valid"}, {31'b0, out_valid}, 1);
    chk({tag, "_q"}, {{(31-N){1'b0}}, out_q}, {{(31-N){1'b0}}, exp});
  endtask

  // Called at a negedge with the DUT ready to accept.
  task automatic send_and_wait(input string tag, input logic [WL-1:0] w, input logic [N:0] exp);
    in_valid = 1'b1;
    in_z = w;
    #1;
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_z = WL'($urandom);
    wait_result(tag, exp);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle_valid"}, {31'b0, out_valid}, 0);
  endtask

  logic [WL-1:0] words[6] = '{16'h0000, 16'hC000, 16'h8000, 16'hAAAA, 16'h5555, 16'h9000};
  logic [N:0]    exps[6]  = '{9'h000, 9'h000, 9'h080, 9'h0FF, 9'h101, 9'h040};

  logic [N:0]    exp_q[$];
  logic [N:0]    hold_val;
  logic [N:0]    popped;
  logic [WL-1:0] word_a;
  logic          hold_pending;
  logic          acc;
  int            n_in, n_out;

  initial begin
    // Reset state
    #1;
    chk("reset_out_valid", {31'b0, out_valid}, 0);
    chk("reset_out_q", {{(31-N){1'b0}}, out_q}, 0);
    chk("reset_in_ready", {31'b0, in_ready}, 1);
    @(negedge clk);
    rst = 1'b0;

    // Directed words; the first goes in on the first edge after reset release
    for (int i = 0; i < 6; i++) begin
      send_and_wait($sformatf("dir%0d", i), words[i], exps[i]);
      release_out($sformatf("dir%0d", i));
    end

    // Back-pressure in DONE, then back-to-back acceptance of a second word
    send_and_wait("hold_first", 16'h8000, 9'h080);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_z = 16'hAAAA;
      out_ready = 1'b0;
      #1;
      chk("hold_valid", {31'b0, out_valid}, 1);
      chk("hold_q", {{(31-N){1'b0}}, out_q}, 32'h080);
      chk("hold_in_ready", {31'b0, in_ready}, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", {31'b0, in_ready}, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    wait_result("b2b_second", 9'h0FF);
    release_out("b2b");

    // in_valid and in_z churning during CONV must not affect the result
    word_a = WL'($urandom);
    in_valid = 1'b1;
    in_z = word_a;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      in_valid = 1'($urandom);
      in_z = WL'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("churn_valid", {31'b0, out_valid}, 1);
    chk("churn_q", {{(31-N){1'b0}}, out_q}, {{(31-N){1'b0}}, ref_val(word_a)});
    release_out("churn");

    // Asynchronous reset in the middle of a conversion
    in_valid = 1'b1;
    in_z = 16'hAAAA;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 0);
    chk("midrst_out_q", {{(31-N){1'b0}}, out_q}, 0);
    chk("midrst_in_ready", {31'b0, in_ready}, 1);
    @(negedge clk);
    rst = 1'b0;
    send_and_wait("after_rst", 16'h5555, 9'h101);
    release_out("after_rst");

    // Randomised traffic against a queue of expected results
    hold_pending = 1'b0;
    n_in = 0;
    n_out = 0;
    for (int c = 0; c < 30000; c++) begin
      if (!in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_z = WL'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (hold_pending) begin
        chk("rand_hold_valid", {31'b0, out_valid}, 1);
        chk("rand_hold_q", {{(31-N){1'b0}}, out_q}, {{(31-N){1'b0}}, hold_val});
      end
      if (out_valid && out_ready) begin
        chk("rand_queue_nonempty", {31'b0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) begin
          popped = exp_q.pop_front();
          chk("rand_q", {{(31-N){1'b0}}, out_q}, {{(31-N){1'b0}}, popped});
        end
        n_out++;
        hold_pending = 1'b0;
      end else if (out_valid) begin
        hold_pending = 1'b1;
        hold_val = out_q;
      end else begin
        hold_pending = 1'b0;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back(ref_val(in_z));
        n_in++;
      end
      @(posedge clk);
      @(negedge clk);
      if (acc) in_valid = 1'b0;
    end

    // Drain whatever is still in flight
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4 * (N + 2) && exp_q.size() != 0; c++) begin
      #1;
      if (out_valid) begin
        popped = exp_q.pop_front();
        chk("drain_q", {{(31-N){1'b0}}, out_q}, {{(31-N){1'b0}}, popped});
        n_out++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("drain_empty", exp_q.size(), 0);
    chk("words_in_eq_out", n_out, n_in);
    chk("words_enough", {31'b0, n_in > 1000}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
